// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker
//   Exhaustive equivalence sweep for an N_IN-input Boolean function.
//   Every input vector 0 .. 2^N_IN-1 is driven out on vec_out. After SETTLE
//   wait cycles the function output(s) are sampled and compared:
//     mode 0 : f_a against f_b (original vs minimised implementation)
//     mode 1 : f_a against tt_ref[vec_out] (implementation vs truth table)
//   Results are the mismatch count, the lowest failing vector and pass/fail.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle sweep request (ignored while busy)
//   mode              comparison mode, captured when start is accepted
//   tt_ref            reference truth table, bit i = expected f at vector i
//   f_a, f_b          sampled function outputs
//   vec_out           vector currently applied (MSB = variable A)
//   busy, done        sweep running / results valid
//   pass              no mismatches (meaningful when done=1)
//   mismatch_cnt      mismatching vectors, 0 .. 2^N_IN
//   first_fail_vec    lowest mismatching vector
//   first_fail_valid  first_fail_vec holds a captured vector
module equiv_sweep_checker #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [(1<<N_IN)-1:0]   tt_ref,
    input  logic                   f_a,
    input  logic                   f_b,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_fail_vec,
    output logic                   first_fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [N_IN-1:0] VEC_LAST  = '1;
    localparam logic [N_IN-1:0] VEC_ONE   = 1;
    localparam logic [N_IN:0]   CNT_ONE   = 1;
    localparam logic [3:0]      WAIT_ONE  = 4'd1;
    localparam logic [3:0]      WAIT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvld_q, ffvld_d;

    logic              exp_bit;
    logic              mism;
    state_e            vec_entry;

    // Case-inequality so that X/Z on a compared input is reported as a mismatch.
    always_comb begin
        exp_bit = mode_q ? tt_ref[vec_q] : f_b;
        mism    = (f_a !== exp_bit);
    end

    // Each new vector starts in SETTLE, or directly in SAMPLE with no settle time.
    always_comb begin
        if (SETTLE == 0) vec_entry = S_SAMPLE;
        else             vec_entry = S_SETTLE;
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        vec_d   = vec_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        ffv_d   = ffv_q;
        ffvld_d = ffvld_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = vec_entry;
                    wait_d  = '0;
                    vec_d   = '0;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    ffv_d   = '0;
                    ffvld_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_SAMPLE;
                end else begin
                    wait_d  = wait_q + WAIT_ONE;
                end
            end
            S_SAMPLE: begin
                if (mism) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!ffvld_q) begin
                        ffv_d   = vec_q;
                        ffvld_d = 1'b1;
                    end
                end
                // The last vector holds on vec_out; pass uses the count
                // including this final sample.
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                end else begin
                    vec_d   = vec_q + VEC_ONE;
                    state_d = vec_entry;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            vec_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            ffv_q   <= '0;
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_cnt     = cnt_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Bench for equiv_sweep_checker: instance 0 is N_IN=3/SETTLE=1, instance 1
// is N_IN=4/SETTLE=0. A sweep-level model predicts every output on every
// cycle from the number of cycles elapsed since the accepted start.
module tb_equiv_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start [2];
    logic        md    [2];
    logic [15:0] ta    [2];
    logic [15:0] tb    [2];
    logic [15:0] tt    [2];

    logic [2:0]  vec0, ffv0;
    logic [3:0]  cnt0;
    logic [3:0]  vec1, ffv1;
    logic [4:0]  cnt1;
    logic        busy_w [2];
    logic        done_w [2];
    logic        pass_w [2];
    logic        ffvld_w[2];
    logic        fa0, fb0, fa1, fb1;

    assign fa0 = ta[0][vec0];
    assign fb0 = tb[0][vec0];
    assign fa1 = ta[1][vec1];
    assign fb1 = tb[1][vec1];

    equiv_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .mode(md[0]),
        .tt_ref(tt[0][7:0]), .f_a(fa0), .f_b(fb0),
        .vec_out(vec0), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .mismatch_cnt(cnt0), .first_fail_vec(ffv0), .first_fail_valid(ffvld_w[0])
    );

    equiv_sweep_checker #(.N_IN(4), .SETTLE(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .mode(md[1]),
        .tt_ref(tt[1]), .f_a(fa1), .f_b(fb1),
        .vec_out(vec1), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .mismatch_cnt(cnt1), .first_fail_vec(ffv1), .first_fail_valid(ffvld_w[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- sweep-level model ----------------
    // phase: 0 idle/reset, 1 sweeping, 2 done. k = edges since accepted start.
    localparam int NV  [2] = '{8, 16};
    localparam int SP1 [2] = '{2, 1};
    int  phase [2] = '{0, 0};
    int  kc    [2] = '{0, 0};
    bit  mm    [2][16];
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                phase[d] = 0;
                kc[d]    = 0;
            end else if (start[d] && phase[d] != 1) begin
                phase[d] = 1;
                kc[d]    = 0;
                for (int v = 0; v < 16; v++)
                    mm[d][v] = md[d] ? (ta[d][v] != tt[d][v]) : (ta[d][v] != tb[d][v]);
            end else if (phase[d] == 1) begin
                kc[d]++;
                if (kc[d] == NV[d] * SP1[d]) phase[d] = 2;
            end
        end
        if (rst) mvalid = 1'b1;
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int d = 0; d < 2; d++) begin
                int sampled, ecnt, efirst, evec;
                bit evld, ebusy, edone, epass;
                int avec, acnt, affv;
                string p;
                p = (d == 0) ? "A." : "B.";
                avec = (d == 0) ? int'(vec0) : int'(vec1);
                acnt = (d == 0) ? int'(cnt0) : int'(cnt1);
                affv = (d == 0) ? int'(ffv0) : int'(ffv1);
                sampled = 0; ecnt = 0; efirst = 0; evld = 0;
                ebusy = 0; edone = 0; epass = 0; evec = 0;
                if (phase[d] != 0) begin
                    sampled = kc[d] / SP1[d];
                    if (sampled > NV[d]) sampled = NV[d];
                    for (int v = 0; v < sampled; v++)
                        if (mm[d][v]) begin
                            ecnt++;
                            if (!evld) begin efirst = v; evld = 1; end
                        end
                    evec  = (sampled > NV[d] - 1) ? NV[d] - 1 : sampled;
                    ebusy = (phase[d] == 1);
                    edone = (phase[d] == 2);
                    epass = edone && (ecnt == 0);
                end
                chk({p, "busy"},  int'(busy_w[d]),  int'(ebusy));
                chk({p, "done"},  int'(done_w[d]),  int'(edone));
                chk({p, "pass"},  int'(pass_w[d]),  int'(epass));
                chk({p, "vec"},   avec,             evec);
                chk({p, "cnt"},   acnt,             ecnt);
                chk({p, "ffvld"}, int'(ffvld_w[d]), int'(evld));
                chk({p, "ffv"},   affv,             efirst);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    // Returns the number of cycles busy was observed high; timeout is a failure.
    task automatic wait_done(input int d, output int nb);
        int n;
        n = 0; nb = 0;
        while (!done_w[d] && n < 300) begin
            if (busy_w[d]) nb++;
            tick();
            n++;
        end
        tests++;
        if (!done_w[d]) begin
            fails++;
            $display("FAIL timeout_done%0d: done=%0d required 1", d, done_w[d]);
        end
    endtask

    task automatic wait_vec0(input int v);
        int n;
        n = 0;
        while (int'(vec0) != v && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (int'(vec0) != v) begin
            fails++;
            $display("FAIL timeout_vec: vec=%0d required %0d", vec0, v);
        end
    endtask

    function automatic bit f_fn(input int v);
        bit a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return (!b) | (!a & !c);
    endfunction

    function automatic bit g_fn(input int v);
        bit a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return (a & b) | (b & c);
    endfunction

    logic [15:0] ftab, gtab;
    int nb;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; md[d] = 1'b0;
            ta[d] = '0; tb[d] = '0; tt[d] = '0;
        end
        ftab = '0; gtab = '0;
        for (int v = 0; v < 8; v++) begin
            ftab[v] = f_fn(v);
            gtab[v] = g_fn(v);
        end
        repeat (3) tick();
        chk("reset_busy", int'(busy_w[0]), 0);
        chk("reset_done", int'(done_w[0]), 0);
        chk("reset_cnt",  int'(cnt0), 0);
        chk("ftab_pin",   int'(ftab[7:0]), 'h37);
        chk("gtab_pin",   int'(gtab[7:0]), 'hC8);
        rst = 1'b0;
        tick();

        // f_a == f_b
        md[0] = 1'b0; ta[0] = ftab; tb[0] = ftab;
        pulse_start(0);
        wait_done(0, nb);
        chk("eq_busy_cycles", nb, 16);
        chk("eq_pass", int'(pass_w[0]), 1);
        chk("eq_cnt", int'(cnt0), 0);
        chk("eq_ffvld", int'(ffvld_w[0]), 0);

        // f_b is the exact complement
        tb[0] = gtab;
        pulse_start(0);
        wait_done(0, nb);
        chk("cmp_cnt", int'(cnt0), 8);
        chk("cmp_pass", int'(pass_w[0]), 0);
        chk("cmp_ffv", int'(ffv0), 0);
        chk("cmp_ffvld", int'(ffvld_w[0]), 1);

        // truth-table mode
        md[0] = 1'b1; tt[0] = 16'h0037;
        pulse_start(0);
        wait_done(0, nb);
        chk("tt37_pass", int'(pass_w[0]), 1);
        tt[0] = 16'h0033;
        pulse_start(0);
        wait_done(0, nb);
        chk("tt33_cnt", int'(cnt0), 1);
        chk("tt33_ffv", int'(ffv0), 2);
        chk("tt33_pass", int'(pass_w[0]), 0);

        // N_IN=4, SETTLE=0
        md[1] = 1'b0; ta[1] = 16'hA5C3; tb[1] = 16'hA5C3;
        pulse_start(1);
        wait_done(1, nb);
        chk("b_busy_cycles", nb, 16);
        chk("b_vec_hold", int'(vec1), 15);
        tick(); tick();
        chk("b_vec_hold2", int'(vec1), 15);
        chk("b_pass", int'(pass_w[1]), 1);

        // reset mid-sweep at vector 5, then a fresh sweep
        md[0] = 1'b0; ta[0] = ftab; tb[0] = gtab;
        pulse_start(0);
        wait_vec0(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_vec", int'(vec0), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_ffvld", int'(ffvld_w[0]), 0);
        pulse_start(0);
        wait_done(0, nb);
        chk("fresh_busy_cycles", nb, 16);
        chk("fresh_cnt", int'(cnt0), 8);

        // start while busy is ignored; start in DONE restarts
        pulse_start(0);
        wait_vec0(2);
        pulse_start(0);
        wait_done(0, nb);
        chk("ign_cnt", int'(cnt0), 8);
        chk("ign_ffv", int'(ffv0), 0);
        pulse_start(0);
        chk("restart_busy", int'(busy_w[0]), 1);
        chk("restart_done", int'(done_w[0]), 0);
        chk("restart_cnt", int'(cnt0), 0);
        wait_done(0, nb);

        // randomized sweeps, checked cycle by cycle against the model
        for (int i = 0; i < 20; i++) begin
            int d;
            d = i % 2;
            md[d] = 1'(($urandom % 2));
            ta[d] = 16'($urandom);
            tb[d] = ($urandom % 3 == 0) ? ta[d] : 16'($urandom);
            tt[d] = ($urandom % 3 == 0) ? ta[d] : 16'($urandom);
            pulse_start(d);
            if ($urandom % 2 == 0) begin
                repeat ($urandom_range(0, 8)) tick();
                pulse_start(d);
            end
            wait_done(d, nb);
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Sequential, parametrised successor to our combinational minimisation blocks.
- Exhaustively enumerates all 2^N_IN input vectors of an N_IN-input Boolean function and drives each vector out.
- After a settle delay, samples one or two function outputs. In mode 0 it compares two implementations (original vs minimised); in mode 1 it compares one implementation against a truth table.
- Reports pass/fail, the mismatch count and the first failing vector; replaces the hand-written stimulus sweep used with those blocks.

Parameters:
- N_IN, 3, number of function inputs (1..8); vector space is 2^N_IN.
- SETTLE, 1, wait cycles after driving a vector before sampling (0..15).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- mode  input  1  0: compare f_a vs f_b; 1: compare f_a vs tt_ref[vec_out]. Captured at start.
- tt_ref  input  2^N_IN  reference truth table; bit i = expected f at vector i. Must be stable while busy.
- f_a  input  1  output of the function under test.
- f_b  input  1  output of the second implementation (mode 0 only).
- vec_out  output  N_IN  current input vector; MSB = first variable (A).
- busy  output  1  sweep in progress.
- done  output  1  results valid; held until the next accepted start or reset.
- pass  output  1  1 if zero mismatches; valid when done=1.
- mismatch_cnt  output  N_IN+1  number of mismatching vectors.
- first_fail_vec  output  N_IN  lowest vector that mismatched.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. Reset takes effect on any clock edge, including mid-sweep, where the sweep is aborted and no results are kept.
- FSM states:
  - IDLE: wait for start.
  - SETTLE: count SETTLE cycles; skipped when SETTLE=0.
  - SAMPLE: compare the sampled outputs.
  - DONE: hold results until the next start.
- start when IDLE or DONE (accepted):
  - Next edge: busy=1, done=0, pass=0, vec_out=0, mismatch_cnt=0, first_fail_valid=0, first_fail_vec=0.
  - mode is latched.
  - FSM goes to SETTLE, or to SAMPLE when SETTLE=0.
- start while busy is ignored.
- SETTLE: wait counter runs 0..SETTLE-1, then FSM goes to SAMPLE.
- SAMPLE, comparing f_a with f_b (mode 0) or with tt_ref[vec_out] (mode 1):
  - On mismatch, mismatch_cnt increments. If first_fail_valid=0, first_fail_vec=vec_out and first_fail_valid=1.
  - In simulation, a non-0/1 value on a compared input counts as a mismatch (case-inequality semantics).
- After SAMPLE:
  - If vec_out != all-ones: vec_out increments and the FSM returns to SETTLE (or to SAMPLE when SETTLE=0).
  - If vec_out == all-ones: the last sample is folded into the results. Next edge: DONE, busy=0, done=1, pass=(final mismatch_cnt==0). vec_out holds all-ones; it does not wrap.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - busy is high for exactly 2^N_IN*(SETTLE+1) cycles.
  - done rises on the edge after the last SAMPLE.
- Width rule: mismatch_cnt never overflows; its maximum is 2^N_IN.
- Simultaneous start and rst: rst wins.
- In mode 0, tt_ref is ignored. In mode 1, f_b is ignored.

Test Plan:
- N_IN=3, SETTLE=1, mode 0, f_a=f_b=(~B)|(~A&~C), start pulse -> busy high 16 cycles; done=1, pass=1, mismatch_cnt=0, first_fail_valid=0.
- Same setup, f_b=(A&B)|(B&C) (exact complement of f_a) -> mismatch_cnt=8, pass=0, first_fail_vec=3'b000, first_fail_valid=1.
- mode 1, tt_ref=8'h37, f_a=(~B)|(~A&~C) -> pass=1. Then tt_ref=8'h33 -> mismatch_cnt=1, first_fail_vec=3'b010.
- N_IN=4, SETTLE=0, f_a=f_b, start -> vec_out steps 0..15 on consecutive cycles; busy high exactly 16 cycles; vec_out stays 4'hF in DONE.
- Assert rst at vector 5 mid-sweep -> all outputs 0 on the next edge and FSM in IDLE. Then start -> a full fresh sweep with correct results.
- Pulse start again at vector 2 while busy -> ignored, sweep completes normally. start in DONE -> results cleared and a new sweep begins.
